// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready stage-buffer bus: upstream push side, downstream pop side and occupancy.
// The slave modport is the buffer itself; the master modport is the surrounding pipeline.
interface pipe_stage_buffer_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-entry circular queue between two pipeline stages with valid/ready and flush.
// Optional zero-latency empty-buffer bypass is enabled by defining PIPE_BYPASS_EN.
module pipe_stage_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic stored_valid;
  logic in_ready;
  logic bypass;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = ptr + PW'(1);
    end
  endfunction

  // Handshake qualification and next-state for pointers and occupancy.
  always_comb begin
    stored_valid = (count_q != {CW{1'b0}});
    in_ready     = (count_q < CW'(DEPTH)) | bus.out_ready;
`ifdef PIPE_BYPASS_EN
    bypass       = ~stored_valid & bus.in_valid & ~flush;
`else
    bypass       = 1'b0;
`endif
    // A bypassed entry taken in the same cycle never touches storage.
    push         = bus.in_valid & in_ready & ~flush & ~(bypass & bus.out_ready);
    pop          = stored_valid & bus.out_ready & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Output view: bypass path first, then the head entry, zero when nothing is live.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.count     = count_q;
    bus.out_valid = stored_valid | bypass;
    if (bypass) begin
      bus.out_data = bus.in_data;
    end else if (stored_valid) begin
      bus.out_data = mem_q[rd_ptr_q];
    end else begin
      bus.out_data = {WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy registers; reset dominates flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push & ~reset) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end
endmodule
